pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
Generic parametrised pipeline stage register for the MIPS pipeline. It is the successor to the fixed per-stage IF/ID/EX/MEM/WB registers. It replaces the global En/Clr stall scheme with a valid/ready handshake, an optional 2-entry skid buffer, and flush-to-bubble with PC preservation. A saturating stall counter feeds the performance-monitor logic. One instance sits between each pair of adjacent pipeline stages; the payload is the concatenated stage control/data bundle.

Parameters:
DW, 64, payload width in bits (concatenated control + data fields)
PCW, 30, PC field width (PC[31:2])
RESET_PC, 30'h0C00, PC value after reset (byte address 0x0000_3000 >> 2)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
KEEP_PC_ON_FLUSH, 1, 1 = a flushed bubble carries in_pc; 0 = a flushed bubble carries RESET_PC
CW, 16, stall counter width

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  reset, asynchronous, active-high
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_data  input  DW  upstream payload
in_pc  input  PCW  upstream PC[31:2]
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts a beat
out_data  output  DW  payload to downstream
out_pc  output  PCW  PC of the presented beat, or of the bubble
flush  input  1  synchronous kill of all held and incoming beats
occupancy  output  2  number of beats held (0..2)
stall_cnt  output  CW  cycles with out_valid=1 and out_ready=0, saturating
stall_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Handshake definitions:
  - acc = in_valid & in_ready (beat accepted).
  - pop = out_valid & out_ready (beat delivered).
  - All state updates occur on the rising edge of Clk.
- Reset (asynchronous, immediate):
  - out_valid=0, out_data=0, out_pc=RESET_PC, occupancy=0, stall_cnt=0.
  - Skid entry cleared.
  - in_ready=1 while Reset is deasserted and the stage is empty.
- Storage:
  - Main entry drives out_data/out_pc.
  - Skid entry exists only when SKID=1.
- State machine for SKID=1, states EMPTY(0), ONE(1), TWO(2); occupancy encodes the state.
  - EMPTY: on acc, main<=in and go to ONE.
  - ONE, acc & pop: main<=in, stay in ONE.
  - ONE, acc & ~pop: skid<=in, go to TWO.
  - ONE, ~acc & pop: go to EMPTY; main data holds its value, out_valid=0.
  - TWO: on pop, main<=skid and go to ONE. acc is impossible in TWO.
  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
  - There is no combinational path from out_ready to in_ready.
- SKID=0:
  - Only EMPTY/ONE exist.
  - in_ready = ~out_valid | out_ready (combinational).
  - In ONE, acc & pop loads the new beat; 1-cycle throughput.
- Latency: an accepted beat appears on out_* on the cycle after acc when the stage was EMPTY, or ONE with a simultaneous pop.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Data ordering is strictly FIFO; beats are never duplicated or dropped except by flush.
- Flush (highest priority after Reset):
  - Next state is EMPTY, out_valid=0, out_data=0, skid cleared.
  - out_pc <= in_pc if KEEP_PC_ON_FLUSH=1, else RESET_PC.
  - A beat accepted in the flush cycle is discarded.
  - A pop in the flush cycle still completes for the downstream.
  - in_ready is 1 in the cycle after a flush.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready.
  - Saturates at 2^CW-1 and does not wrap.
  - stall_clr sets it to 0 and takes priority over the increment.
  - Flush does not affect stall_cnt.
- out_pc when EMPTY holds its last value (last delivered PC or bubble PC).
- Reset asserted mid-transfer: all state is lost immediately; no partial beat is presented after release.

Test Plan:
- Reset release: out_valid=0, out_pc=30'h0C00, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming (SKID=1): out_ready=1, beats D0..D3 = 0x11..0x44 on consecutive cycles -> out_data 0x11..0x44 on consecutive cycles, each 1 cycle after acc, occupancy stays 1.
- Backpressure: out_ready=0 while sending 0xA1, then 0xA2 -> occupancy=2, in_ready=0 next cycle, stall_cnt increments each cycle. Then out_ready=1 -> 0xA1 then 0xA2 delivered in order, in_ready=1 after the first pop.
- Flush with 2 beats held, in_pc=30'h0C10 presented, KEEP_PC_ON_FLUSH=1 -> next cycle out_valid=0, out_data=0, out_pc=30'h0C10, occupancy=0. With KEEP_PC_ON_FLUSH=0 -> out_pc=30'h0C00.
- Counter saturation (CW=4): hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=15. Assert stall_clr with stall persisting -> 0 next cycle, then 1.
- SKID=0 build: out_ready toggling 1,0,1 -> in_ready follows out_ready combinationally while full; no beat is lost or duplicated across 8 beats.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush-to-bubble with PC preservation and stall counter.
module pipe_stage_hs #(
  parameter int unsigned           DW               = 64,
  parameter int unsigned           PCW              = 30,
  parameter logic [PCW-1:0]        RESET_PC         = PCW'(32'h0000_0C00),
  parameter int unsigned           SKID             = 1,
  parameter int unsigned           KEEP_PC_ON_FLUSH = 1,
  parameter int unsigned           CW               = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [PCW-1:0] in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [PCW-1:0] out_pc,
  input  logic           flush,
  output logic [1:0]     occupancy,
  output logic [CW-1:0]  stall_cnt,
  input  logic           stall_clr
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]     r_state;
  logic [1:0]     w_next_state;
  logic [DW-1:0]  r_data;
  logic [PCW-1:0] r_pc;
  logic [DW-1:0]  w_skid_data;
  logic [PCW-1:0] w_skid_pc;
  logic [PCW-1:0] w_flush_pc;
  logic [CW-1:0]  r_stall;
  logic           w_acc;
  logic           w_pop;
  logic           w_in_ready;
  logic           w_load_in;
  logic           w_load_skid;

  assign out_valid  = (r_state != S_EMPTY);
  assign out_data   = r_data;
  assign out_pc     = r_pc;
  assign occupancy  = r_state;
  assign stall_cnt  = r_stall;
  assign in_ready   = w_in_ready;
  assign w_acc      = in_valid & w_in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_flush_pc = (KEEP_PC_ON_FLUSH != 0) ? in_pc : RESET_PC;

  always_comb begin
    w_next_state = r_state;
    w_load_in    = 1'b0;
    w_load_skid  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_next_state = S_ONE;
          w_load_in    = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_pop) begin
          w_load_in = 1'b1;
        end else if (w_acc) begin
          w_next_state = S_TWO;
        end else if (w_pop) begin
          w_next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_pop) begin
          w_next_state = S_ONE;
          w_load_skid  = 1'b1;
        end
      end
      default: w_next_state = S_EMPTY;
    endcase
    if (flush) begin
      w_next_state = S_EMPTY;
      w_load_in    = 1'b0;
      w_load_skid  = 1'b0;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic           r_in_ready;
      logic [DW-1:0]  r_skid_data;
      logic [PCW-1:0] r_skid_pc;

      // in_ready is precomputed from next state so out_ready never reaches it combinationally
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_in_ready  <= 1'b1;
          r_skid_data <= '0;
          r_skid_pc   <= '0;
        end else begin
          r_in_ready <= (w_next_state != S_TWO);
          if (flush) begin
            r_skid_data <= '0;
            r_skid_pc   <= '0;
          end else if ((r_state == S_ONE) && w_acc && !w_pop) begin
            r_skid_data <= in_data;
            r_skid_pc   <= in_pc;
          end
        end
      end

      assign w_in_ready  = r_in_ready & ~Reset;
      assign w_skid_data = r_skid_data;
      assign w_skid_pc   = r_skid_pc;
    end else begin : g_noskid
      assign w_in_ready  = (~out_valid | out_ready) & ~Reset;
      assign w_skid_data = '0;
      assign w_skid_pc   = '0;
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      if (flush) begin
        r_data <= '0;
        r_pc   <= w_flush_pc;
      end else if (w_load_in) begin
        r_data <= in_data;
        r_pc   <= in_pc;
      end else if (w_load_skid) begin
        r_data <= w_skid_data;
        r_pc   <= w_skid_pc;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_stall <= '0;
    end else if (stall_clr) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && (r_stall != '1)) begin
      r_stall <= r_stall + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs: two SKID=1 builds sharing stimulus
// (different flush-PC policy and counter width) plus one SKID=0 build.
module tb_pipe_stage_hs;
  localparam int unsigned DW  = 64;
  localparam int unsigned PCW = 30;
  typedef logic [DW+PCW-1:0] beat_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic           in_valid, out_ready, flush, stall_clr;
  logic [DW-1:0]  in_data;
  logic [PCW-1:0] in_pc;

  logic           a_in_ready, a_out_valid;
  logic [DW-1:0]  a_out_data;
  logic [PCW-1:0] a_out_pc;
  logic [1:0]     a_occ;
  logic [3:0]     a_stall;

  logic           b_in_ready, b_out_valid;
  logic [DW-1:0]  b_out_data;
  logic [PCW-1:0] b_out_pc;
  logic [1:0]     b_occ;
  logic [15:0]    b_stall;

  logic           c_in_valid, c_out_ready, c_in_ready, c_out_valid;
  logic [DW-1:0]  c_in_data, c_out_data;
  logic [PCW-1:0] c_in_pc, c_out_pc;
  logic [1:0]     c_occ;
  logic [15:0]    c_stall;

  int    n_cmp  = 0;
  int    n_err  = 0;
  int    c_pops = 0;
  beat_t qa[$];
  beat_t qc[$];
  beat_t ea, ec;

  pipe_stage_hs #(.DW(DW), .PCW(PCW), .RESET_PC(30'h0C00), .SKID(1),
                  .KEEP_PC_ON_FLUSH(1), .CW(4)) u_a (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_pc(a_out_pc), .flush(flush), .occupancy(a_occ),
    .stall_cnt(a_stall), .stall_clr(stall_clr));

  pipe_stage_hs #(.DW(DW), .PCW(PCW), .RESET_PC(30'h0C00), .SKID(1),
                  .KEEP_PC_ON_FLUSH(0), .CW(16)) u_b (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_pc(b_out_pc), .flush(flush), .occupancy(b_occ),
    .stall_cnt(b_stall), .stall_clr(stall_clr));

  pipe_stage_hs #(.DW(DW), .PCW(PCW), .RESET_PC(30'h0C00), .SKID(0),
                  .KEEP_PC_ON_FLUSH(1), .CW(16)) u_c (
    .Clk(Clk), .Reset(Reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_pc(c_in_pc), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_pc(c_out_pc), .flush(flush), .occupancy(c_occ),
    .stall_cnt(c_stall), .stall_clr(stall_clr));

  // Mid-cycle monitors: decide what the next rising edge will pop/accept.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (a_out_valid && out_ready) begin
        n_cmp++;
        if (qa.size() == 0) begin
          n_err++;
          $display("FAIL sb_a: got data=%h pc=%h, expected no beat", a_out_data, a_out_pc);
        end else begin
          ea = qa.pop_front();
          if ({a_out_data, a_out_pc} !== ea) begin
            n_err++;
            $display("FAIL sb_a: got data=%h pc=%h, expected data=%h pc=%h",
                     a_out_data, a_out_pc, ea[DW+PCW-1:PCW], ea[PCW-1:0]);
          end
        end
      end
      if (in_valid && a_in_ready) qa.push_back({in_data, in_pc});
      if (flush) qa.delete();
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (c_out_valid && c_out_ready) begin
        c_pops++;
        n_cmp++;
        if (qc.size() == 0) begin
          n_err++;
          $display("FAIL sb_c: got data=%h pc=%h, expected no beat", c_out_data, c_out_pc);
        end else begin
          ec = qc.pop_front();
          if ({c_out_data, c_out_pc} !== ec) begin
            n_err++;
            $display("FAIL sb_c: got data=%h pc=%h, expected data=%h pc=%h",
                     c_out_data, c_out_pc, ec[DW+PCW-1:PCW], ec[PCW-1:0]);
          end
        end
      end
      if (c_in_valid && c_in_ready) qc.push_back({c_in_data, c_in_pc});
      if (flush) qc.delete();
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", a_out_valid); end
    n_cmp++; if (a_out_pc !== 30'h0C00) begin n_err++; $display("FAIL rst_out_pc: got %h expected 0c00", a_out_pc); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", a_in_ready); end
    n_cmp++; if (a_occ !== 2'd0) begin n_err++; $display("FAIL rst_occ: got %0d expected 0", a_occ); end
    n_cmp++; if (a_stall !== 4'd0) begin n_err++; $display("FAIL rst_stall: got %0d expected 0", a_stall); end
    n_cmp++; if (a_out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h expected 0", a_out_data); end
    n_cmp++; if (c_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_c_in_ready: got %b expected 1", c_in_ready); end
    tick();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp_d;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(17 * (k + 1));
      in_pc    = 30'(32'h0C00 + k);
      exp_d    = in_data;
      tick();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== exp_d) begin n_err++; $display("FAIL stream_lat%0d: got v=%b d=%h expected v=1 d=%h", k, a_out_valid, a_out_data, exp_d); end
      n_cmp++; if (a_occ !== 2'd1) begin n_err++; $display("FAIL stream_occ%0d: got %0d expected 1", k, a_occ); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", a_out_valid, a_occ); end
    n_cmp++; if (a_out_data !== 64'h44) begin n_err++; $display("FAIL stream_hold: got %h expected 44", a_out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA1; in_pc = 30'h0C20;
    tick();
    n_cmp++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first: got occ=%0d rdy=%b expected occ=1 rdy=1", a_occ, a_in_ready); end
    in_data = 64'hA2; in_pc = 30'h0C21;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0", a_occ, a_in_ready); end
    n_cmp++; if (a_stall !== 4'd1) begin n_err++; $display("FAIL bp_stall1: got %0d expected 1", a_stall); end
    tick();
    n_cmp++; if (a_stall !== 4'd2 || a_out_data !== 64'hA1) begin n_err++; $display("FAIL bp_stall2: got cnt=%0d d=%h expected cnt=2 d=a1", a_stall, a_out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (a_out_data !== 64'hA2 || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_pop1: got d=%h occ=%0d rdy=%b expected d=a2 occ=1 rdy=1", a_out_data, a_occ, a_in_ready); end
    n_cmp++; if (a_stall !== 4'd2) begin n_err++; $display("FAIL bp_stall_hold: got %0d expected 2", a_stall); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin n_err++; $display("FAIL bp_pop2: got v=%b occ=%0d expected v=0 occ=0", a_out_valid, a_occ); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hB1; in_pc = 30'h0C28;
    tick();
    in_data = 64'hB2; in_pc = 30'h0C29;
    tick();
    flush = 1'b1; in_data = 64'hDEAD; in_pc = 30'h0C10;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_occ !== 2'd0) begin n_err++; $display("FAIL flush_a: got v=%b d=%h occ=%0d expected v=0 d=0 occ=0", a_out_valid, a_out_data, a_occ); end
    n_cmp++; if (a_out_pc !== 30'h0C10) begin n_err++; $display("FAIL flush_keep_pc: got %h expected 0c10", a_out_pc); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b expected 1", a_in_ready); end
    n_cmp++; if (b_out_pc !== 30'h0C00 || b_out_data !== '0 || b_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_reset_pc: got pc=%h d=%h v=%b expected pc=0c00 d=0 v=0", b_out_pc, b_out_data, b_out_valid); end
    // pop and accept in the same cycle as a flush
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hC1; in_pc = 30'h0C2F;
    tick();
    flush = 1'b1; in_data = 64'hC2; in_pc = 30'h0C30;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (a_out_valid !== 1'b0 || a_out_pc !== 30'h0C30) begin n_err++; $display("FAIL flush_pop: got v=%b pc=%h expected v=0 pc=0c30", a_out_valid, a_out_pc); end
    tick();
    n_cmp++; if (a_out_pc !== 30'h0C30 || a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_pc_hold: got v=%b pc=%h expected v=0 pc=0c30", a_out_valid, a_out_pc); end
  endtask

  task automatic test_stall_sat();
    stall_clr = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    tick();
    stall_clr = 1'b0;
    n_cmp++; if (a_stall !== 4'd0 || b_stall !== 16'd0) begin n_err++; $display("FAIL sat_clr0: got a=%0d b=%0d expected 0/0", a_stall, b_stall); end
    in_valid = 1'b1; in_data = 64'hD1; in_pc = 30'h0C50;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    n_cmp++; if (a_stall !== 4'd15) begin n_err++; $display("FAIL sat_cw4: got %0d expected 15", a_stall); end
    n_cmp++; if (b_stall !== 16'd20) begin n_err++; $display("FAIL sat_cw16: got %0d expected 20", b_stall); end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    n_cmp++; if (a_stall !== 4'd0) begin n_err++; $display("FAIL sat_clr_prio: got %0d expected 0", a_stall); end
    tick();
    n_cmp++; if (a_stall !== 4'd1) begin n_err++; $display("FAIL sat_restart: got %0d expected 1", a_stall); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_noskid();
    int   sent  = 0;
    int   occ_m = 0;
    int   cyc   = 0;
    logic exp_rdy, acc, pop;
    while ((sent < 8 || occ_m != 0) && cyc < 100) begin
      c_in_valid  = (sent < 8);
      c_in_data   = 64'(sent) + 64'hE0;
      c_in_pc     = 30'(32'h0D00 + sent);
      c_out_ready = (sent >= 8) ? 1'b1 : ((cyc % 3) != 1);
      #1;
      exp_rdy = (occ_m == 0) || c_out_ready;
      n_cmp++; if (c_in_ready !== exp_rdy) begin n_err++; $display("FAIL noskid_rdy c%0d: got %b expected %b", cyc, c_in_ready, exp_rdy); end
      acc = c_in_valid && exp_rdy;
      pop = (occ_m == 1) && c_out_ready;
      if (acc) sent++;
      occ_m = acc ? 1 : (pop ? 0 : occ_m);
      tick();
      cyc++;
    end
    c_in_valid = 1'b0;
    if (cyc >= 100) begin n_cmp++; n_err++; $display("FAIL noskid_timeout: got %0d beats sent expected 8", sent); end
    n_cmp++; if (c_pops !== 8) begin n_err++; $display("FAIL noskid_count: got %0d pops expected 8", c_pops); end
    n_cmp++; if (c_occ !== 2'd0 || qc.size() != 0) begin n_err++; $display("FAIL noskid_empty: got occ=%0d pending=%0d expected 0/0", c_occ, qc.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hF1; in_pc = 30'h0C40;
    tick();
    in_data = 64'hF2; in_pc = 30'h0C41;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (a_occ !== 2'd2) begin n_err++; $display("FAIL rmid_fill: got %0d expected 2", a_occ); end
    #2;
    Reset = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_pc !== 30'h0C00 || a_out_data !== '0) begin n_err++; $display("FAIL rmid_async: got v=%b occ=%0d pc=%h d=%h expected 0/0/0c00/0", a_out_valid, a_occ, a_out_pc, a_out_data); end
    qa.delete();
    qc.delete();
    tick();
    Reset = 1'b0;
    tick();
    n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_stall !== 4'd0) begin n_err++; $display("FAIL rmid_release: got v=%b rdy=%b cnt=%0d expected 0/1/0", a_out_valid, a_in_ready, a_stall); end
  endtask

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    in_data = '0; in_pc = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_in_pc = '0;
    repeat (3) @(posedge Clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_noskid();
    test_reset_mid();
    n_cmp++; if (qa.size() != 0) begin n_err++; $display("FAIL sb_a_leftover: got %0d pending expected 0", qa.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
